effects_chain_sequencer: RTL

//  Run-time scheduler for the audio effects chain (delay, compression, limiter, bitcrusher).

---
 rtl/audio_fx_pkg.sv | 44 ++++
 rtl/stage_watchdog.sv | 49 ++++
 rtl/effects_chain_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_fx_pkg.sv
// ---------------------------------------------------------------------------
// audio_fx_pkg
// Shared types and constants for the audio effects chain sequencer.
//   SAMPLE_W / NUM_STAGES / STAGE_IDX_W : datapath and slot geometry
//   seq_state_t                         : sequencer FSM encoding
//   stage_id_t                          : effect stage identifiers
//   order_slot() / stage_onehot()       : slot-to-stage decode helpers
// ---------------------------------------------------------------------------
package audio_fx_pkg;

    localparam int SAMPLE_W        = 12;
    localparam int NUM_STAGES      = 4;
    localparam int STAGE_IDX_W     = 2;
    localparam int ORDER_W         = NUM_STAGES * STAGE_IDX_W;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } seq_state_t;

    typedef enum logic [STAGE_IDX_W-1:0] {
        DELAY = 2'd0,
        COMP  = 2'd1,
        LIMIT = 2'd2,
        CRUSH = 2'd3
    } stage_id_t;

    typedef logic [STAGE_IDX_W-1:0]     stage_idx_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Stage index programmed into a given slot of the order word.
    function automatic stage_idx_t order_slot(input logic [ORDER_W-1:0] order,
                                              input stage_idx_t         slot);
        return order[slot*STAGE_IDX_W +: STAGE_IDX_W];
    endfunction

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_idx_t s);
        return NUM_STAGES'(1) << s;
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// ---------------------------------------------------------------------------
// stage_watchdog
// Counts cycles spent waiting on one effect stage and flags expiry so the
// sequencer can bypass a stage that never reports done.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : restart the count (asserted with the stage start)
//   enable       : count this cycle (asserted while waiting)
//   expired      : this enabled cycle is the TIMEOUT-th since clear
// The counter saturates at TIMEOUT so it never wraps during a long stall.
// ---------------------------------------------------------------------------
module stage_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // count_q holds the number of earlier waiting cycles, so the waiting
    // cycle that brings the total to TIMEOUT is the one that expires.
    assign expired = enable && !clear && (count_q >= CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/effects_chain_sequencer.sv
// ---------------------------------------------------------------------------
// effects_chain_sequencer
// Runs each accepted audio sample through up to four effect stages, one at
// a time, over a shared sample bus, then hands it to the AC97 path.
//   clock, reset        : system clock, synchronous active-high reset
//   playback            : samples are accepted only while high
//   new_sample_ready    : one-cycle strobe, samples_in valid
//   samples_in          : signed input sample
//   stage_enable        : per-stage enable (0 = bypass)
//   stage_order         : slot k runs stage stage_order[2k+1:2k]
//   stage_start         : one-hot, one-cycle start to a stage
//   stage_sample        : working sample broadcast to all stages
//   stage_result        : stage i result at [12i+11:12i]
//   stage_done          : per-stage result-valid strobe
//   to_ac97_data        : processed sample, held until the next one
//   sample_ready        : one-cycle strobe, to_ac97_data is new
//   overrun             : one-cycle strobe, an input sample was dropped
//   timeout_err         : sticky, a stage watchdog expired
// Build option EFFECTS_SEQ_SKID_EN: adds a one-entry skid register that
// holds one sample arriving while busy; it is accepted right after OUTPUT.
//
// state  | meaning
// IDLE   | waiting for an accepted sample (or a held skid sample)
// LAUNCH | one cycle per slot: start the slot's stage or skip it
// WAIT   | waiting for the started stage's done or watchdog expiry
// OUTPUT | present the work sample to the AC97 path for one cycle
// ---------------------------------------------------------------------------
module effects_chain_sequencer
    import audio_fx_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           playback,
    input  logic                           new_sample_ready,
    input  logic signed [SAMPLE_W-1:0]     samples_in,
    input  logic [NUM_STAGES-1:0]          stage_enable,
    input  logic [ORDER_W-1:0]             stage_order,
    output logic [NUM_STAGES-1:0]          stage_start,
    output logic signed [SAMPLE_W-1:0]     stage_sample,
    input  logic [NUM_STAGES*SAMPLE_W-1:0] stage_result,
    input  logic [NUM_STAGES-1:0]          stage_done,
    output logic signed [SAMPLE_W-1:0]     to_ac97_data,
    output logic                           sample_ready,
    output logic                           overrun,
    output logic                           timeout_err
);

    seq_state_t            state_q,       state_d;
    stage_idx_t            slot_q,        slot_d;
    sample_t               work_q,        work_d;
    sample_t               ac97_q,        ac97_d;
    logic [ORDER_W-1:0]    order_q,       order_d;
    logic [NUM_STAGES-1:0] en_q,          en_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  overrun_q,     overrun_d;
`ifdef EFFECTS_SEQ_SKID_EN
    logic                  skid_valid_q,  skid_valid_d;
    sample_t               skid_data_q,   skid_data_d;
`endif

    stage_idx_t cur_stage;
    logic       last_slot;
    logic       arrival;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;

    assign cur_stage = order_slot(order_q, slot_q);
    assign last_slot = (slot_q == STAGE_IDX_W'(NUM_STAGES - 1));
    assign arrival   = playback && new_sample_ready;
    assign wd_enable = (state_q == WAIT);

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        work_d        = work_q;
        ac97_d        = ac97_q;
        order_d       = order_q;
        en_d          = en_q;
        timeout_err_d = timeout_err_q;
        overrun_d     = 1'b0;
        stage_start   = '0;
        sample_ready  = 1'b0;
        wd_clear      = 1'b0;
`ifdef EFFECTS_SEQ_SKID_EN
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef EFFECTS_SEQ_SKID_EN
                // The held sample is older, so it goes first; a sample
                // arriving in the same cycle refills the freed skid slot.
                if (skid_valid_q && playback) begin
                    work_d       = skid_data_q;
                    order_d      = stage_order;
                    en_d         = stage_enable;
                    slot_d       = '0;
                    state_d      = LAUNCH;
                    skid_valid_d = arrival;
                    if (arrival) begin
                        skid_data_d = samples_in;
                    end
                end else if (arrival) begin
                    work_d  = samples_in;
                    order_d = stage_order;
                    en_d    = stage_enable;
                    slot_d  = '0;
                    state_d = LAUNCH;
                end
`else
                if (arrival) begin
                    work_d  = samples_in;
                    order_d = stage_order;
                    en_d    = stage_enable;
                    slot_d  = '0;
                    state_d = LAUNCH;
                end
`endif
            end

            LAUNCH: begin
                if (en_q[cur_stage]) begin
                    stage_start = stage_onehot(cur_stage);
                    wd_clear    = 1'b1;
                    state_d     = WAIT;
                end else if (last_slot) begin
                    state_d = OUTPUT;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end

            WAIT: begin
                // done has priority over a watchdog expiry in the same cycle
                if (stage_done[cur_stage] || wd_expired) begin
                    if (stage_done[cur_stage]) begin
                        work_d = stage_result[cur_stage*SAMPLE_W +: SAMPLE_W];
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                    if (last_slot) begin
                        state_d = OUTPUT;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end

            OUTPUT: begin
                sample_ready = 1'b1;
                ac97_d       = work_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && arrival) begin
`ifdef EFFECTS_SEQ_SKID_EN
            if (!skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = samples_in;
            end else begin
                overrun_d = 1'b1;
            end
`else
            overrun_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            work_q        <= '0;
            ac97_q        <= '0;
            order_q       <= '0;
            en_q          <= '0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef EFFECTS_SEQ_SKID_EN
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            work_q        <= work_d;
            ac97_q        <= ac97_d;
            order_q       <= order_d;
            en_q          <= en_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
`ifdef EFFECTS_SEQ_SKID_EN
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
`endif
        end
    end

    // The new sample is visible during the OUTPUT cycle itself and is then
    // held by ac97_q until the next OUTPUT.
    assign to_ac97_data = (state_q == OUTPUT) ? work_q : ac97_q;
    assign stage_sample = work_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;

endmodule
